// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants and types for the bus-mapped GCD block.
// Register offsets, STATUS/CTRL bit positions and the core FSM states.
package gcd_pkg;

    localparam logic [15:0] OFF_A1     = 16'h0;
    localparam logic [15:0] OFF_A2     = 16'h2;
    localparam logic [15:0] OFF_W      = 16'h4;
    localparam logic [15:0] OFF_CTRL   = 16'h6;
    localparam logic [15:0] OFF_STATUS = 16'h8;
    localparam logic [15:0] OFF_CNT    = 16'hA;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_BUSY = 3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

endpackage

// File: rtl/gcd_core.sv
// gcd_core: subtractive-Euclid engine with zero handling and step timeout.
// Ports: clk, n_reset, start, op_a/op_b in; busy, done_pulse, err, result, iter out.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_ITER = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done_pulse,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  iter
);

    localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  iter_q, iter_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
        end
    end

    // Completion checks run before the timeout check, so a run that
    // converges on exactly the last allowed step still succeeds.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        iter_d     = iter_q;
        done_pulse = 1'b0;
        err        = 1'b0;
        result     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    iter_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (a_q == '0 || b_q == '0) begin
                    result     = a_q | b_q;
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end else if (a_q == b_q) begin
                    result     = a_q;
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end else if (iter_q == ITER_MAX) begin
                    err        = 1'b1;
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                    iter_d = iter_q + 1'b1;
                end
            end
        endcase
    end

    assign busy = (state_q == S_CALC);
    assign iter = iter_q;

endmodule

// File: rtl/gcd_bus_periph.sv
// gcd_bus_periph: GCD accelerator register window on the 16-bit CPU bus.
// Ports: clk, n_reset, saddress, srd, swr, sdata_in in; sdata_out, irq out.
module gcd_bus_periph
    import gcd_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [15:0] BASE_ADDR = 16'h0100,
    parameter int          MAX_ITER  = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic        irq
);

    localparam logic [15:0] ADDR_A1     = BASE_ADDR + OFF_A1;
    localparam logic [15:0] ADDR_A2     = BASE_ADDR + OFF_A2;
    localparam logic [15:0] ADDR_W      = BASE_ADDR + OFF_W;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + OFF_CTRL;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + OFF_STATUS;
    localparam logic [15:0] ADDR_CNT    = BASE_ADDR + OFF_CNT;

    logic sel_a1, sel_a2, sel_w;
    logic sel_ctrl, sel_status, sel_cnt;

    assign sel_a1     = (saddress == ADDR_A1);
    assign sel_a2     = (saddress == ADDR_A2);
    assign sel_w      = (saddress == ADDR_W);
    assign sel_ctrl   = (saddress == ADDR_CTRL);
    assign sel_status = (saddress == ADDR_STATUS);
    assign sel_cnt    = (saddress == ADDR_CNT);

    // A combined read+write strobe is treated as a write only.
    logic rd_en;
    assign rd_en = srd & ~swr;

    logic [DATA_W-1:0] a1_q, a2_q, w_q;
    logic              irq_en_q;
    logic              done_q, err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              core_start;
    logic              core_busy;
    logic              core_done;
    logic              core_err;
    logic [DATA_W-1:0] core_result;
    logic [CNT_W-1:0]  core_iter;

    assign core_start = swr & sel_ctrl & sdata_in[CTRL_START];

    gcd_core #(
        .DATA_W   (DATA_W),
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_core (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (core_start),
        .op_a       (a1_q),
        .op_b       (a2_q),
        .busy       (core_busy),
        .done_pulse (core_done),
        .err        (core_err),
        .result     (core_result),
        .iter       (core_iter)
    );

    // The core drops START while busy; flags must ignore it as well.
    logic start_acc;
    assign start_acc = core_start & ~core_busy;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_q     <= '0;
            a2_q     <= '0;
            irq_en_q <= 1'b0;
        end else if (swr) begin
            if (sel_a1) a1_q <= sdata_in[DATA_W-1:0];
            if (sel_a2) a2_q <= sdata_in[DATA_W-1:0];
            if (sel_ctrl) irq_en_q <= sdata_in[CTRL_IRQ_EN];
        end
    end

    // A fresh completion wins over a same-cycle clear-on-read of W.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            w_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (core_done) begin
            w_q    <= core_result;
            done_q <= 1'b1;
            err_q  <= core_err;
            cnt_q  <= cnt_q + 1'b1;
        end else if (start_acc || (rd_en && sel_w)) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    logic [31:0] status_word;
    logic [31:0] ctrl_word;
    logic [31:0] cnt_word;
    logic [31:0] rd_data;

    always_comb begin
        status_word          = '0;
        status_word[ST_DONE] = done_q;
        status_word[ST_ERR]  = err_q;
        status_word[ST_BUSY] = core_busy;
        ctrl_word              = '0;
        ctrl_word[CTRL_IRQ_EN] = irq_en_q;
    end

    assign cnt_word = {16'(cnt_q), 16'(core_iter)};

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            sel_a1:     rd_data = 32'(a1_q);
            sel_a2:     rd_data = 32'(a2_q);
            sel_w:      rd_data = 32'(w_q);
            sel_ctrl:   rd_data = ctrl_word;
            sel_status: rd_data = status_word;
            sel_cnt:    rd_data = cnt_word;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sdata_out <= '0;
        end else if (rd_en) begin
            sdata_out <= rd_data;
        end
    end

    assign irq = done_q & irq_en_q;

    // Bits of the write bus above DATA_W and unused CTRL bits.
    logic unused_wr_bits;
    assign unused_wr_bits = &{1'b0, sdata_in};

endmodule

// File: doc/gcd_bus_periph.md
Name: gcd_bus_periph

Overview:
Bus-mapped, width-parametrised GCD accelerator for the GPIO emulator CPU bus (saddress/srd/swr/sdata_in/sdata_out).
- Software writes two operands, writes a start bit, then polls status and reads the result.
- Uses the subtractive Euclid algorithm, with added zero-operand handling, an iteration timeout with error flag, an iteration counter and a completed-results counter.
- Sits beside the GPIO register block on the same 16-bit address bus.

Parameters:
DATA_W, 32, operand/result width (1..32); bus values zero-extended to 32 bits on read, truncated on write
BASE_ADDR, 16'h0100, base of 6-word register window
MAX_ITER, 1024, subtraction-step limit before timeout error (>=1)
CNT_W, 16, width of ITER and DONE_CNT registers

Ports:
clk  in  1  system clock; all state on posedge
n_reset  in  1  asynchronous active-low reset
saddress  in  16  bus address
srd  in  1  read strobe, one cycle
swr  in  1  write strobe, one cycle
sdata_in  in  32  write data
sdata_out  out  32  registered read data
irq  out  1  level interrupt = done & IRQ_EN

Behaviour:
- Reset: one clock; asynchronous, active-low (n_reset).
- On n_reset=0 immediately clear:
  - A1, A2, W, ITER, DONE_CNT, CTRL to 0
  - state to IDLE, busy/done/err to 0
  - sdata_out=0, irq=0
- Reset mid-computation aborts with no result.

Register map (offset from BASE_ADDR):
- 0x0 A1 (RW)
- 0x2 A2 (RW)
- 0x4 W (RO)
- 0x6 CTRL (W: bit0 START self-clearing, bit1 IRQ_EN; reads bit1 only)
- 0x8 STATUS (RO: bit0 done, bit1 err, bit3 busy)
- 0xA ITER(RO)/DONE_CNT(RO) = {DONE_CNT[15:0], ITER[15:0]}

Writes:
- Take effect on the posedge where swr=1.
- A1/A2 writes while busy are accepted but do not affect the running computation; operands are latched at start.

Reads:
- On the posedge where srd=1, sdata_out <= selected register, zero-extended.
- Unmapped address returns 0.
- sdata_out holds between reads.
- srd&swr together: write is performed, sdata_out is unchanged.
- Reading W clears done and err (clear-on-read); the read returns the pre-clear W.

FSM states: IDLE, CALC.
- IDLE, START write accepted:
  - a<=A1, b<=A2, ITER<=0
  - busy=1, done=0, err=0
  - go to CALC
- CALC, evaluated each cycle in priority order:
  - a==0 or b==0: W<=a|b, done=1, go to IDLE (gcd(0,0)=0, no err)
  - a==b: W<=a, done=1, go to IDLE
  - ITER==MAX_ITER: W<=0, err=1, done=1, go to IDLE
  - else: subtract the smaller from the larger, ITER<=ITER+1
- START written while busy: ignored, no flag change.
- Latency: done=1 is visible ITER+1 cycles after the start edge.
- DONE_CNT increments on every completion (ok or err) and wraps modulo 2^CNT_W.
- ITER saturates at MAX_ITER and holds its value until the next start.
- busy=1 exactly while the state is CALC.
- irq follows done&IRQ_EN combinationally from registers.

Decomposition:
- Package gcd_pkg holds:
  - register offset constants
  - STATUS bit indices (DONE=0, ERR=1, BUSY=3)
  - CTRL bit indices
  - FSM state enum
- Sub-module gcd_core (DATA_W, MAX_ITER, CNT_W) holds the a/b datapath, FSM and ITER. Interface: start, op_a, op_b in; busy, done_pulse, err, result, iter out.
- gcd_bus_periph holds the address decode, registers, flags, DONE_CNT and read mux.

Test Plan:
- Reset mid-run: set A1=48, A2=18, start; drop n_reset at cycle 2 -> all registers 0 and busy=0 immediately; no completion after release.
- Basic GCD: A1=48, A2=18, start -> busy for 5 cycles, STATUS=0x1, W=6, ITER=4, DONE_CNT=1; read W -> STATUS=0x0.
- Zero operands:
  - A1=0, A2=35, start -> W=35, ITER=0, done after 1 cycle.
  - A1=0, A2=0 -> W=0, err=0.
- Timeout (MAX_ITER=8): A1=100, A2=1 -> err=1, done=1, W=0, ITER=8 after 9 cycles; irq=1 when IRQ_EN=1.
- Busy protection: start gcd(21,14); during CALC write A1=99 and START -> result W=7, DONE_CNT +1 only; A1 reads back 99.
- Bus corners:
  - Read unmapped BASE+0xC -> sdata_out=0.
  - srd&swr to A1=5 -> A1=5, sdata_out unchanged.
  - DATA_W=8, write A1=0x1FF -> A1 reads 0xFF.
